store_seq_ctrl: RTL and testbench

Sequencer for the byte-wide 32-bit shift store (Compute_store). It accepts a byte stream over a valid/ready handshake and loads NBYTES bytes into the store. It then runs a start/done handshake with the downstream compute stage. Finally it unloads the store one byte at a time onto a valid/ready output stream. It sits between the byte input interface and the store, and owns the store's load_store and enable_output controls.

---
 rtl/store_seq_pkg.sv | 17 +
 rtl/store_seq_ctrl.sv | 108 ++++++++++
 tb/tb_store_seq_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_seq_pkg.sv
// Shared types for the shift-store sequencer: FSM state encoding and the
// default frame length.
package store_seq_pkg;

  // Bytes per frame; matches a 32-bit store loaded one byte at a time.
  localparam int unsigned NBYTES_DEFAULT = 4;

  // Frame life cycle: fill the store, hand off to compute, then drain it.
  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_PRESENT = 3'd4
  } state_e;

endpackage

// File: rtl/store_seq_ctrl.sv
// Sequencer around the byte-wide shift store: loads one frame of bytes,
// runs a start/done handshake with the compute stage, then unloads the
// store one byte per SHIFT/PRESENT pair onto a valid/ready stream.
module store_seq_ctrl
  import store_seq_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       store_load,
  output logic [7:0] store_data,
  output logic       store_enable_output,
  input  logic [7:0] store_f,
  output logic       compute_start,
  input  logic       compute_done,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  // A one-byte frame would give a zero-width counter; keep at least one bit.
  localparam int unsigned   CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             cnt_at_last;

  // Handshake and store controls decode straight from the state register so
  // the store sees load/enable in the same cycle as the byte handshake.
  assign in_ready            = (state_q == ST_LOAD) & ~flush;
  assign accept              = in_valid & in_ready;
  assign store_load          = accept;
  assign store_data          = in_data;
  assign compute_start       = (state_q == ST_START) & ~flush;
  assign store_enable_output = (state_q == ST_SHIFT) & ~flush;
  assign out_valid           = (state_q == ST_PRESENT);
  assign out_data            = out_valid ? store_f : 8'h00;
  assign busy                = (state_q != ST_LOAD) | (cnt_q != '0);
  assign cnt_at_last         = (cnt_q == CNT_LAST);

  // Next-state and byte-counter logic; flush overrides every transition.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (cnt_at_last) begin
              cnt_d   = '0;
              state_d = ST_START;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_START: state_d = ST_WAIT;
        ST_WAIT: begin
          if (compute_done) state_d = ST_SHIFT;
        end
        ST_SHIFT: state_d = ST_PRESENT;
        ST_PRESENT: begin
          if (out_ready) begin
            if (cnt_at_last) begin
              cnt_d   = '0;
              state_d = ST_LOAD;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = ST_SHIFT;
            end
          end
        end
        default: begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers with asynchronous return to an idle LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (!reset_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_store_seq_ctrl.sv
// Bench for store_seq_ctrl paired with a behavioural shift store. A
// frame-level model (queue of bytes plus phase flags) predicts every output
// each cycle; directed scenarios add literal expectations; a random phase
// exercises gaps, stalls and flushes.
module tb_store_seq_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       store_load;
  logic [7:0] store_data;
  logic       store_enable_output;
  logic [7:0] store_f;
  logic       compute_start;
  logic       compute_done = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_seq_ctrl #(.NBYTES(N)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .store_load          (store_load),
    .store_data          (store_data),
    .store_enable_output (store_enable_output),
    .store_f             (store_f),
    .compute_start       (compute_start),
    .compute_done        (compute_done),
    .out_valid           (out_valid),
    .out_data            (out_data),
    .out_ready           (out_ready),
    .busy                (busy)
  );

  // Behavioural 32-bit shift store: bytes enter at the bottom, F takes the top.
  logic [31:0] store_sr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_sr <= 32'h0;
      store_f  <= 8'h00;
    end else if (store_load) begin
      store_sr <= {store_sr[23:0], store_data};
    end else if (store_enable_output) begin
      store_f  <= store_sr[31:24];
      store_sr <= {store_sr[23:0], 8'h00};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: bytes of the current frame plus the phase it is in.
  logic [7:0] m_q[$];
  bit m_fill = 1'b1, m_pulse = 1'b0, m_wait = 1'b0, m_shift = 1'b0, m_show = 1'b0;

  function automatic void model_idle();
    m_q.delete();
    m_fill  = 1'b1;
    m_pulse = 1'b0;
    m_wait  = 1'b0;
    m_shift = 1'b0;
    m_show  = 1'b0;
  endfunction

  // Per-cycle compare against the model, then advance the model one edge.
  always @(negedge clk) begin
    logic       e_rdy, e_ld, e_st, e_en, e_ov, e_busy;
    logic [7:0] e_od;
    if (!reset_n) model_idle();
    e_rdy  = m_fill && !flush;
    e_ld   = e_rdy && in_valid;
    e_st   = m_pulse && !flush;
    e_en   = m_shift && !flush;
    e_ov   = m_show;
    e_od   = m_show ? m_q[0] : 8'h00;
    e_busy = !m_fill || (m_q.size() != 0);
    check("in_ready", {31'h0, in_ready}, {31'h0, e_rdy});
    check("store_load", {31'h0, store_load}, {31'h0, e_ld});
    if (e_ld) check("store_data", {24'h0, store_data}, {24'h0, in_data});
    check("compute_start", {31'h0, compute_start}, {31'h0, e_st});
    check("store_enable_output", {31'h0, store_enable_output}, {31'h0, e_en});
    check("out_valid", {31'h0, out_valid}, {31'h0, e_ov});
    check("out_data", {24'h0, out_data}, {24'h0, e_od});
    check("busy", {31'h0, busy}, {31'h0, e_busy});
    if (reset_n) begin
      if (flush) begin
        model_idle();
      end else if (m_fill) begin
        if (in_valid) begin
          m_q.push_back(in_data);
          if (m_q.size() == N) begin
            m_fill  = 1'b0;
            m_pulse = 1'b1;
          end
        end
      end else if (m_pulse) begin
        m_pulse = 1'b0;
        m_wait  = 1'b1;
      end else if (m_wait) begin
        if (compute_done) begin
          m_wait  = 1'b0;
          m_shift = 1'b1;
        end
      end else if (m_shift) begin
        m_shift = 1'b0;
        m_show  = 1'b1;
      end else if (m_show && out_ready) begin
        void'(m_q.pop_front());
        m_show = 1'b0;
        if (m_q.size() == 0) m_fill = 1'b1;
        else m_shift = 1'b1;
      end
    end
  end

  // Event monitor feeding the literal expectations of the directed scenarios.
  int         cyc = 0;
  int         mon_loads, mon_run, mon_maxrun, mon_last_load_cyc;
  int         mon_starts, mon_start_cyc, mon_ens, mon_first_ov_cyc;
  bit         mon_seen_ov;
  logic [7:0] mon_out[$];

  always @(negedge clk) begin
    cyc++;
    if (store_load) begin
      mon_loads++;
      mon_run++;
      mon_last_load_cyc = cyc;
      if (mon_run > mon_maxrun) mon_maxrun = mon_run;
    end else begin
      mon_run = 0;
    end
    if (compute_start) begin
      mon_starts++;
      mon_start_cyc = cyc;
    end
    if (store_enable_output) mon_ens++;
    if (out_valid && !mon_seen_ov) begin
      mon_seen_ov      = 1'b1;
      mon_first_ov_cyc = cyc;
    end
    if (out_valid && out_ready) mon_out.push_back(out_data);
  end

  task automatic clear_mon();
    mon_loads = 0; mon_run = 0; mon_maxrun = 0; mon_last_load_cyc = 0;
    mon_starts = 0; mon_start_cyc = 0; mon_ens = 0; mon_first_ov_cyc = 0;
    mon_seen_ov = 1'b0;
    mon_out.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present four bytes (first byte in the top of frame), optionally with an
  // idle cycle after each one.
  task automatic load_frame(input logic [31:0] frame, input bit gaps);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = frame[31-8*i -: 8];
      tick();
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'h5A;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // Drain one frame; the byte at hold_idx is stalled for hold_cycles cycles.
  task automatic unload(input int hold_idx, input int hold_cycles, input logic [7:0] hold_byte);
    int idx = 0;
    int held = 0;
    int guard = 0;
    while (idx < N && guard < 300) begin
      if (out_valid) begin
        if (idx == hold_idx && held < hold_cycles) begin
          check("hold_data", {24'h0, out_data}, {24'h0, hold_byte});
          check("hold_no_enable", {31'h0, store_enable_output}, 32'h0);
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
          idx++;
        end
      end else begin
        out_ready = 1'b1;
      end
      tick();
      guard++;
    end
    check("unload_bytes_done", idx, N);
  endtask

  task automatic check_frame(input logic [31:0] frame);
    logic [31:0] act;
    check("frame_len", mon_out.size(), N);
    for (int i = 0; i < N; i++) begin
      act = (i < mon_out.size()) ? {24'h0, mon_out[i]} : 32'hFFFF_FFFF;
      check("frame_byte", act, {24'h0, frame[31-8*i -: 8]});
    end
  endtask

  initial begin
    int guard;
    clear_mon();
    model_idle();

    // Reset state.
    tick(); tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    reset_n = 1'b1;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Scenario 1: back-to-back frame, compute_done and out_ready high.
    compute_done = 1'b1;
    out_ready    = 1'b1;
    clear_mon();
    load_frame(32'h11223344, 1'b0);
    unload(-1, 0, 8'h00);
    tick();
    check_frame(32'h11223344);
    check("t1_starts", mon_starts, 1);
    check("t1_start_after_last", mon_start_cyc - mon_last_load_cyc, 1);
    check("t1_latency", mon_first_ov_cyc - mon_last_load_cyc, 4);
    check("t1_load_run", mon_maxrun, 4);
    check("t1_busy_idle", {31'h0, busy}, 32'h0);

    // Scenario 2: compute_done held low for 10 cycles.
    compute_done = 1'b0;
    clear_mon();
    load_frame(32'hA1B2C3D4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t2_wait_no_ov", {31'h0, out_valid}, 32'h0);
      check("t2_wait_no_en", {31'h0, store_enable_output}, 32'h0);
      tick();
    end
    check("t2_busy_in_wait", {31'h0, busy}, 32'h1);
    compute_done = 1'b1;
    unload(-1, 0, 8'h00);
    tick();
    check_frame(32'hA1B2C3D4);

    // Scenario 3: second output byte stalled for 5 cycles.
    clear_mon();
    load_frame(32'h11223344, 1'b0);
    unload(1, 5, 8'h22);
    tick();
    check_frame(32'h11223344);
    check("t3_enables", mon_ens, 4);

    // Scenario 4: flush after two bytes, then a clean frame.
    clear_mon();
    load_frame(32'hAABB0000, 1'b0);
    tick();
    flush = 1'b1;
    check("t4_flush_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    flush = 1'b0;
    check("t4_flush_busy", {31'h0, busy}, 32'h0);
    clear_mon();
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_valid = 1'b1; in_data = 8'hBB; tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_starts_aborted", mon_starts, 0);
    load_frame(32'h01020304, 1'b0);
    unload(-1, 0, 8'h00);
    tick();
    check_frame(32'h01020304);
    check("t4_starts", mon_starts, 1);

    // Scenario 5: asynchronous reset while a byte is presented.
    out_ready = 1'b0;
    load_frame(32'h55667788, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("t5_reached_present", {31'h0, out_valid}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("t5_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    check("t5_rst_enable", {31'h0, store_enable_output}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    clear_mon();
    load_frame(32'h99AABBCC, 1'b0);
    unload(-1, 0, 8'h00);
    tick();
    check_frame(32'h99AABBCC);

    // Scenario 6: in_valid toggling during load.
    clear_mon();
    load_frame(32'h0BADF00D, 1'b1);
    check("t6_loads", mon_loads, 4);
    check("t6_load_run", mon_maxrun, 1);
    check("t6_starts", mon_starts, 1);
    check("t6_start_after_4th", mon_start_cyc - mon_last_load_cyc, 1);
    unload(-1, 0, 8'h00);
    tick();
    check_frame(32'h0BADF00D);

    // Random phase: gaps, compute delays, output stalls and rare flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      in_data      = 8'($urandom);
      compute_done = 1'($urandom_range(0, 1));
      out_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
